// File: rtl/dutb_run_ctrl.sv
// rtl/dutb_run_ctrl.sv - run sequencer: slot grants, result tally, final status
module dutb_run_ctrl #(
    parameter int P_MAX_FAIL_NUM    = 16,
    parameter int P_MAX_TXN_NUM     = 1024,
    parameter int P_MAX_OUTSTANDING = 4,
    parameter int P_TIMEOUT_CYCLES  = 4096,
    parameter int P_CNT_WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    output logic                   drv_req_o,
    input  logic                   drv_ack_i,
    input  logic                   chk_valid_i,
    input  logic                   chk_pass_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2:0]             status_o,
    output logic [P_CNT_WIDTH-1:0] txn_cnt_o,
    output logic [P_CNT_WIDTH-1:0] pass_cnt_o,
    output logic [P_CNT_WIDTH-1:0] fail_cnt_o,
    output logic                   err_o
);
    localparam int WD_W = (P_TIMEOUT_CYCLES > 2) ? $clog2(P_TIMEOUT_CYCLES) : 1;

    localparam logic [P_CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [P_CNT_WIDTH-1:0] TXN_MAX  = P_CNT_WIDTH'(P_MAX_TXN_NUM);
    localparam logic [P_CNT_WIDTH-1:0] FAIL_MAX = P_CNT_WIDTH'(P_MAX_FAIL_NUM);
    localparam logic [7:0]             OUT_MAX  = 8'(P_MAX_OUTSTANDING);
    localparam logic [WD_W-1:0]        WD_LAST  = WD_W'(P_TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]        WD_SAT   = '1;

    localparam logic [2:0] ST_NONE       = 3'd0;
    localparam logic [2:0] ST_PASS       = 3'd1;
    localparam logic [2:0] ST_FAIL       = 3'd2;
    localparam logic [2:0] ST_FAIL_LIMIT = 3'd3;
    localparam logic [2:0] ST_TIMEOUT    = 3'd4;
    localparam logic [2:0] ST_ABORT      = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [P_CNT_WIDTH-1:0] txn, txn_n, pass, pass_n, fail, fail_n;
    logic [7:0]             outs, outs_n;
    logic [WD_W-1:0]        wdog, wdog_n;
    logic [2:0]             status, status_n;
    logic                   err, err_n;
    logic                   issue, res_ok;

    assign busy_o     = (state == RUN);
    assign done_o     = (state == DONE);
    assign drv_req_o  = busy_o && (txn < TXN_MAX) && (outs < OUT_MAX);
    assign issue      = drv_req_o && drv_ack_i;
    // A result is only accepted if something is (or is becoming) in flight
    assign res_ok     = busy_o && chk_valid_i && ((outs != 8'd0) || issue);
    assign status_o   = status;
    assign txn_cnt_o  = txn;
    assign pass_cnt_o = pass;
    assign fail_cnt_o = fail;
    assign err_o      = err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            txn    <= '0;
            pass   <= '0;
            fail   <= '0;
            outs   <= '0;
            wdog   <= '0;
            status <= ST_NONE;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            txn    <= txn_n;
            pass   <= pass_n;
            fail   <= fail_n;
            outs   <= outs_n;
            wdog   <= wdog_n;
            status <= status_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        txn_n    = txn;
        pass_n   = pass;
        fail_n   = fail;
        outs_n   = outs;
        wdog_n   = wdog;
        status_n = status;
        err_n    = err;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    state_n  = RUN;
                    txn_n    = '0;
                    pass_n   = '0;
                    fail_n   = '0;
                    outs_n   = '0;
                    wdog_n   = '0;
                    status_n = ST_NONE;
                    err_n    = 1'b0;
                end
            end
            RUN: begin
                if (issue && txn != CNT_MAX) txn_n = txn + P_CNT_WIDTH'(1);
                if (res_ok && chk_pass_i && pass != CNT_MAX) pass_n = pass + P_CNT_WIDTH'(1);
                if (res_ok && !chk_pass_i && fail != CNT_MAX) fail_n = fail + P_CNT_WIDTH'(1);
                if (issue && !res_ok) outs_n = outs + 8'd1;
                else if (res_ok && !issue) outs_n = outs - 8'd1;
                if (chk_valid_i && !res_ok) err_n = 1'b1;
                if (issue || res_ok) wdog_n = '0;
                else if (wdog != WD_SAT) wdog_n = wdog + WD_W'(1);

                // Exit conditions in priority order, judged on post-update counts
                if (abort_i) begin
                    state_n  = DONE;
                    status_n = ST_ABORT;
                end else if (fail_n == FAIL_MAX) begin
                    state_n  = DONE;
                    status_n = ST_FAIL_LIMIT;
                end else if (wdog == WD_LAST && !issue && !res_ok) begin
                    state_n  = DONE;
                    status_n = ST_TIMEOUT;
                end else if (txn_n == TXN_MAX && outs_n == 8'd0) begin
                    state_n  = DONE;
                    status_n = (fail_n == '0) ? ST_PASS : ST_FAIL;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dutb_run_ctrl.sv
// tb/tb_dutb_run_ctrl.sv - scoreboard bench for dutb_run_ctrl
module tb_dutb_run_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, start_i, abort_i, drv_ack_i, chk_valid_i, chk_pass_i;
    logic        drv_req_o, busy_o, done_o, err_o;
    logic [2:0]  status_o;
    logic [15:0] txn_cnt_o, pass_cnt_o, fail_cnt_o;

    always #5 clk = ~clk;

    dutb_run_ctrl #(
        .P_MAX_FAIL_NUM(3), .P_MAX_TXN_NUM(8), .P_MAX_OUTSTANDING(2),
        .P_TIMEOUT_CYCLES(10), .P_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .drv_req_o(drv_req_o), .drv_ack_i(drv_ack_i), .chk_valid_i(chk_valid_i),
        .chk_pass_i(chk_pass_i), .busy_o(busy_o), .done_o(done_o), .status_o(status_o),
        .txn_cnt_o(txn_cnt_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .err_o(err_o)
    );

    typedef struct {int status; int pass; int fail; int txn;} exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, issued = 0, res_idx = 0, ack_limit = 0, fail_from = 0;
    int pend_due[$];
    bit ack_en = 0, chk_en = 0, force_chk = 0, force_abort = 0, abort_on_last = 0, saw_stall = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: bench driver/checker model picks inputs from registered outputs
    task automatic tick();
        if (busy_o && !drv_req_o && txn_cnt_o < 16'd8) saw_stall = 1;
        drv_ack_i   = ack_en && (issued < ack_limit);
        chk_valid_i = 1'b0;
        chk_pass_i  = 1'b0;
        abort_i     = force_abort;
        if (force_chk) begin
            chk_valid_i = 1'b1;
            chk_pass_i  = 1'b1;
        end else if (chk_en && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            void'(pend_due.pop_front());
            chk_valid_i = 1'b1;
            chk_pass_i  = (res_idx < fail_from);
            if (abort_on_last && res_idx == 7) abort_i = 1'b1;
            res_idx++;
        end
        if (drv_req_o && drv_ack_i) begin
            pend_due.push_back(cyc + 3);
            issued++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sb_push(input int st, input int ps, input int fl, input int tx);
        exp_t e;
        e.status = st; e.pass = ps; e.fail = fl; e.txn = tx;
        sb.push_back(e);
    endtask

    task automatic start_run();
        pend_due.delete();
        issued = 0;
        res_idx = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_eq("start_busy", busy_o, 1);
        check_eq("start_req", drv_req_o, 1);
        check_eq("start_cnt", txn_cnt_o + pass_cnt_o + fail_cnt_o, 0);
        check_eq("start_status", status_o, 0);
        check_eq("start_err", err_o, 0);
    endtask

    task automatic wait_done(input int budget);
        exp_t e;
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        check_eq("done_reached", done_o, 1);
        check_eq("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("status", status_o, e.status);
            if (e.pass >= 0) check_eq("pass_cnt", pass_cnt_o, e.pass);
            if (e.fail >= 0) check_eq("fail_cnt", fail_cnt_o, e.fail);
            if (e.txn  >= 0) check_eq("txn_cnt", txn_cnt_o, e.txn);
        end
    endtask

    initial begin
        int n;
        int fsave;
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        drv_ack_i = 1'b0; chk_valid_i = 1'b0; chk_pass_i = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check_eq("rst_outputs", {busy_o, done_o, drv_req_o, err_o, status_o}, 0);
        check_eq("rst_counts", txn_cnt_o + pass_cnt_o + fail_cnt_o, 0);

        // all pass, two in flight
        ack_en = 1; ack_limit = 100; chk_en = 1; fail_from = 100; saw_stall = 0;
        sb_push(1, 8, 0, 8);
        start_run();
        wait_done(200);
        check_eq("req_stall_seen", saw_stall, 1);
        check_eq("done_req_low", drv_req_o, 0);

        // every result fails
        fail_from = 0;
        sb_push(3, 0, 3, -1);
        start_run();
        wait_done(200);
        fsave = int'(txn_cnt_o);
        repeat (6) tick();
        check_eq("frozen_fail", fail_cnt_o, 3);
        check_eq("frozen_pass", pass_cnt_o, 0);
        check_eq("frozen_txn", txn_cnt_o, fsave);
        check_eq("no_err_in_done", err_o, 0);
        check_eq("limit_req_low", drv_req_o, 0);

        // watchdog: single issue then silence
        ack_limit = 1; chk_en = 0;
        sb_push(4, 0, 0, 1);
        start_run();
        tick();
        n = 0;
        while (!done_o && n < 40) begin
            tick();
            n++;
        end
        check_eq("timeout_cycles", n, 10);
        wait_done(1);

        // abort together with the completing result
        ack_limit = 100; chk_en = 1; fail_from = 100; abort_on_last = 1;
        sb_push(5, -1, 0, 8);
        start_run();
        wait_done(200);
        abort_on_last = 0;

        // third fail is also the completing result
        fail_from = 5;
        sb_push(3, 5, 3, 8);
        start_run();
        wait_done(200);

        // stray result with nothing outstanding
        ack_en = 0; chk_en = 0;
        sb_push(5, 0, 0, 0);
        start_run();
        force_chk = 1;
        tick();
        force_chk = 0;
        check_eq("err_set", err_o, 1);
        check_eq("err_counts", txn_cnt_o + pass_cnt_o + fail_cnt_o, 0);
        repeat (3) tick();
        check_eq("err_sticky", err_o, 1);
        force_abort = 1;
        tick();
        force_abort = 0;
        wait_done(1);
        check_eq("err_kept_in_done", err_o, 1);

        // reset mid-run at txn 5 (start_run checks err cleared)
        ack_en = 1; chk_en = 1; fail_from = 100;
        start_run();
        n = 0;
        while (txn_cnt_o != 16'd5 && n < 100) begin
            tick();
            n++;
        end
        check_eq("txn_reached_5", txn_cnt_o, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("midrst_flags", {busy_o, done_o, drv_req_o, err_o, status_o}, 0);
        check_eq("midrst_counts", txn_cnt_o + pass_cnt_o + fail_cnt_o, 0);
        repeat (2) tick();
        check_eq("idle_holds", {busy_o, done_o}, 0);

        sb_push(1, 8, 0, 8);
        start_run();
        wait_done(200);
        check_eq("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dutb_run_ctrl.md
Name: dutb_run_ctrl

Overview:
- Synthesizable run sequencer for the dutb test environment.
- Grants transaction slots to the stimulus driver and bounds the number of in-flight transactions.
- Tallies checker pass/fail results and ends the run on completion, on reaching the failure limit, on watchdog timeout, or on abort.
- Holds a final status word that the testbench reads.

Parameters:
- P_MAX_FAIL_NUM, 16, failed results that force a stop (FAIL_LIMIT); 1..2^P_CNT_WIDTH-1.
- P_MAX_TXN_NUM, 1024, transactions issued per run; 1..2^P_CNT_WIDTH-1.
- P_MAX_OUTSTANDING, 4, max issued-but-unchecked transactions; 1..255.
- P_TIMEOUT_CYCLES, 4096, idle cycles in RUN with no issue and no result before TIMEOUT; >=2.
- P_CNT_WIDTH, 16, width of the issue/pass/fail counters.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start_i  in  1  begin a run; sampled in IDLE or DONE.
- abort_i  in  1  terminate the run; effective in RUN.
- drv_req_o  out  1  slot available to the driver.
- drv_ack_i  in  1  driver takes the slot; issue = drv_req_o && drv_ack_i.
- chk_valid_i  in  1  checker result valid, one result per cycle max.
- chk_pass_i  in  1  1 = pass, 0 = fail; qualified by chk_valid_i.
- busy_o  out  1  state == RUN.
- done_o  out  1  state == DONE.
- status_o  out  3  0 NONE, 1 PASS, 2 FAIL, 3 FAIL_LIMIT, 4 TIMEOUT, 5 ABORT.
- txn_cnt_o  out  P_CNT_WIDTH  transactions issued.
- pass_cnt_o  out  P_CNT_WIDTH  pass results.
- fail_cnt_o  out  P_CNT_WIDTH  fail results.
- err_o  out  1  sticky protocol error.

Behaviour:
Reset (rst_n == 0 at an edge):
- state = IDLE.
- All counters and the outstanding count = 0; status_o = 0; err_o = 0; busy_o = done_o = drv_req_o = 0.

State machine:
- IDLE -> RUN on start_i.
  - Entering RUN clears txn/pass/fail/outstanding/watchdog counters, status_o and err_o.
- DONE -> RUN on start_i, with the same clears. Otherwise DONE holds all outputs.
- RUN exits to DONE on the first cycle any exit condition holds. Priority, highest first:
  1. abort_i -> ABORT.
  2. Fail count after the current update == P_MAX_FAIL_NUM -> FAIL_LIMIT.
  3. Watchdog == P_TIMEOUT_CYCLES-1 with no issue and no result this cycle -> TIMEOUT.
  4. txn == P_MAX_TXN_NUM and outstanding == 0 after the current update -> PASS if fail == 0, else FAIL.
- status_o and state update together at the same edge.

drv_req_o:
- Combinational from registers: state == RUN && txn < P_MAX_TXN_NUM && outstanding < P_MAX_OUTSTANDING.
- No dependence on drv_ack_i. drv_ack_i while drv_req_o == 0 is ignored.

Outstanding count:
- Issue alone: +1. Result alone: -1. Simultaneous issue and result: unchanged.
- The count never exceeds P_MAX_OUTSTANDING and never goes below 0.

Results:
- chk_valid_i with outstanding == 0 and no same-cycle issue: counters unchanged, err_o set.
- Results and issues outside RUN are ignored, counters frozen. No err_o in DONE.

Watchdog:
- Cleared on any issue or accepted result, otherwise +1 per RUN cycle.
- Saturates. Inactive outside RUN.

Counters:
- Issue/pass/fail counters saturate at 2^P_CNT_WIDTH-1.

Latency:
- First drv_req_o one cycle after start_i is sampled.
- Counters and status_o visible the cycle after the causing edge.

Reset mid-run:
- Returns to IDLE within the same edge. No status is retained.

Test Plan:
1. P_MAX_TXN_NUM=8, P_MAX_OUTSTANDING=2, ack always 1, checker returns pass 3 cycles after each issue -> drv_req_o drops while 2 are in flight; after 8 issues and 8 results: done_o=1, status_o=1, pass_cnt_o=8, fail_cnt_o=0.
2. P_MAX_FAIL_NUM=3, all results fail -> DONE with status_o=3 on the edge after the 3rd fail; fail_cnt_o=3; drv_req_o=0 afterwards; later results leave the counters unchanged.
3. P_TIMEOUT_CYCLES=10, driver never acks after the first issue and the checker stays silent -> status_o=4 exactly 10 cycles after the last activity.
4. abort_i and the final completing result in the same cycle -> status_o=5. Separately, the 3rd fail (P_MAX_FAIL_NUM=3) coinciding with completion -> status_o=3.
5. chk_valid_i with nothing outstanding -> err_o=1 and sticky; counters unchanged; err_o cleared by the next start_i.
6. rst_n=0 in mid-RUN with txn_cnt_o=5 -> next cycle all outputs are 0 and the state is IDLE. A start_i from DONE reruns with the counters cleared.
